data_mem_lsu: RTL

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

---
 rtl/data_mem_lsu.sv | 138 +++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core data port and a request/grant memory bus.
// One access in flight at a time, with load extension and a per-access timeout.
module data_mem_lsu #(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [1:0]        data_byte_en_i,
  input  logic              data_wr_i,
  input  logic [DATA_W-1:0] data_wr_data_i,
  input  logic              data_zero_extnd_i,
  output logic              data_gnt_o,
  output logic              data_busy_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rd_data_o,
  output logic              data_err_o,
  output logic              data_mem_req_o,
  output logic [ADDR_W-1:0] data_mem_addr_o,
  output logic [1:0]        data_mem_byte_en_o,
  output logic              data_mem_wr_o,
  output logic [DATA_W-1:0] data_mem_wr_data_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rd_data_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] BE_BYTE = 2'b00;
  localparam logic [1:0] BE_HALF = 2'b01;

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              active;
  logic              grant;
  logic              rsp_take;
  logic              timeout_hit;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        be_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              zx_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;

  // Sign or zero extension of a raw load word according to the access size.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0]        be,
                                                    input logic              zx);
    logic [DATA_W-1:0] res;
    case (be)
      BE_BYTE: res = {{(DATA_W-8){~zx & raw[7]}}, raw[7:0]};
      BE_HALF: res = {{(DATA_W-16){~zx & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign active      = (state == REQ) || (state == WAIT);
  assign grant       = (state == IDLE) && data_req_i;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = active && (cnt_inc == CNT_LAST);
  // A response is only valid once the memory has taken the request.
  assign rsp_take    = ((state == REQ) && mem_gnt_i && mem_rvalid_i) ||
                       ((state == WAIT) && mem_rvalid_i);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (data_req_i) state_nxt = REQ;
      REQ: begin
        if (rsp_take || timeout_hit) state_nxt = RESP;
        else if (mem_gnt_i)          state_nxt = WAIT;
      end
      WAIT: if (rsp_take || timeout_hit) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      zx_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        cnt     <= '0;
        addr_q  <= data_addr_i;
        be_q    <= data_byte_en_i;
        wr_q    <= data_wr_i;
        wdata_q <= data_wr_data_i;
        zx_q    <= data_zero_extnd_i;
      end else if (active) begin
        cnt <= cnt_inc;
      end
      // Response beats timeout when both land in the same cycle.
      if (rsp_take) begin
        rd_q  <= wr_q ? '0 : load_extend(mem_rd_data_i, be_q, zx_q);
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        rd_q  <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign data_gnt_o         = grant && reset_n;
  assign data_busy_o        = (state != IDLE);
  assign data_rvalid_o      = (state == RESP);
  assign data_rd_data_o     = (state == RESP) ? rd_q : '0;
  assign data_err_o         = (state == RESP) && err_q;
  assign data_mem_req_o     = (state == REQ);
  assign data_mem_addr_o    = addr_q;
  assign data_mem_byte_en_o = be_q;
  assign data_mem_wr_o      = wr_q;
  assign data_mem_wr_data_o = wdata_q;

endmodule
